// File: rtl/line_window_assembler_if.sv
// Column-in / window-out handshake bundle for line_window_assembler.
// slave: block side (consumes columns, produces windows); master: peer side.
interface line_window_assembler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 3,
  parameter int XW           = 10,
  parameter int YW           = 9
);
  localparam int CW = KERNEL_WIDTH * DATA_WIDTH;
  localparam int WW = KERNEL_WIDTH * CW;

  logic [CW-1:0] col_data;
  logic          col_valid;
  logic          col_ready;
  logic [WW-1:0] win_data;
  logic          win_valid;
  logic          win_ready;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          frame_done;
`ifdef LINE_WINDOW_PASS_BORDER_EN
  logic          win_border;

  modport slave (
    input  col_data, col_valid, win_ready,
    output col_ready, win_data, win_valid,
    output win_x, win_y, frame_done,
    output win_border
  );

  modport master (
    output col_data, col_valid, win_ready,
    input  col_ready, win_data, win_valid,
    input  win_x, win_y, frame_done,
    input  win_border
  );
`else
  modport slave (
    input  col_data, col_valid, win_ready,
    output col_ready, win_data, win_valid,
    output win_x, win_y, frame_done
  );

  modport master (
    output col_data, col_valid, win_ready,
    input  col_ready, win_data, win_valid,
    input  win_x, win_y, frame_done
  );
`endif
endinterface

// File: rtl/line_window_assembler.sv
// Builds KxK pixel windows from line-buffer columns, drops left-border
// windows and emits each legal window with its top-left coordinates.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   col_data/col_valid/col_ready in, win_data/win_valid/win_ready out,
//   win_x, win_y, frame_done (+ win_border).
// Option: LINE_WINDOW_PASS_BORDER_EN emits border windows, flagged.
module line_window_assembler #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 3,
  parameter int IMG_WIDTH    = 854,
  parameter int IMG_HEIGHT   = 480,
  parameter int XW           = $clog2(IMG_WIDTH),
  parameter int YW           = $clog2(IMG_HEIGHT)
) (
  input logic                 clk,
  input logic                 rst,
  line_window_assembler_if.slave bus
);
  localparam int K  = KERNEL_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int WW = K * K * DW;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_LEGAL = XW'(K - 1);
  localparam logic [XW-1:0] X_ARM   = XW'(K - 2);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_TOP   = YW'(K - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DW-1:0] win_q [K][K];
  logic [WW-1:0] win_nxt;

  logic [WW-1:0] wd;
  logic          wv;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic          done;

  logic col_ready;
  logic accept;
  logic drain;
  logic load;
  logic x_legal;
  logic x_last;
  logic y_last;

  assign x_legal   = (x >= X_LEGAL);
  assign x_last    = (x == X_LAST);
  assign y_last    = (y == Y_LAST);
  assign col_ready = (state != S_FLUSH)
                  && (!wv || bus.win_ready);
  assign accept    = bus.col_valid && col_ready;
  assign drain     = wv && bus.win_ready;

`ifdef LINE_WINDOW_PASS_BORDER_EN
  logic wb;
  assign load           = accept;
  assign bus.win_border = wb;
`else
  assign load = accept && x_legal;
`endif

  assign bus.col_ready  = col_ready;
  assign bus.win_data   = wd;
  assign bus.win_valid  = wv;
  assign bus.win_x      = wx;
  assign bus.win_y      = wy;
  assign bus.frame_done = done;

  // Window as it will look after the current column shifts in.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      localparam int B = ((r * K) + c) * DW;
      if (c < K - 1) begin : g_old
        assign win_nxt[B +: DW] = win_q[r][c+1];
      end else begin : g_new
        assign win_nxt[B +: DW] =
          bus.col_data[r*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FILL: begin
        if (accept && x == X_ARM)
          state_nxt = S_RUN;
      end
      S_RUN: begin
        if (accept && x_last)
          state_nxt = y_last ? S_FLUSH : S_FILL;
      end
      S_FLUSH: begin
        if (drain)
          state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= Y_TOP;
    end else if (state == S_FLUSH && drain) begin
      x <= '0;
      y <= Y_TOP;
    end else if (accept) begin
      if (x_last) begin
        x <= '0;
        if (!y_last) y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= win_nxt[((r*K)+c)*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv <= 1'b0;
      wd <= '0;
      wx <= '0;
      wy <= '0;
`ifdef LINE_WINDOW_PASS_BORDER_EN
      wb <= 1'b0;
`endif
    end else if (load) begin
      wv <= 1'b1;
      wd <= win_nxt;
      wy <= y - Y_TOP;
`ifdef LINE_WINDOW_PASS_BORDER_EN
      wb <= !x_legal;
      wx <= x_legal ? (x - X_LEGAL) : '0;
`else
      wx <= x - X_LEGAL;
`endif
    end else if (drain) begin
      wv <= 1'b0;
    end
  end

  // Final window drains only in S_FLUSH, so no accept can coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == S_FLUSH) && drain;
  end
endmodule
